// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Contents: loader state enum, memory geometry, word width and header length.
// Optional build macro: IMEM_LOADER_CHECKSUM_EN adds the CKSUM state.
package imem_loader_pkg;

    localparam int unsigned IMEM_ADDR_W = 10;
    localparam int unsigned IMEM_DEPTH  = 2**IMEM_ADDR_W;
    localparam int unsigned IMEM_CNT_W  = 16;
    localparam int unsigned WORD_W      = 32;
    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned HDR_BYTES   = 2;

    typedef enum logic [2:0] {
        ST_HDR_LO = 3'd0,
        ST_HDR_HI = 3'd1,
        ST_DATA   = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CKSUM  = 3'd3,
`endif
        ST_DONE   = 3'd4,
        ST_ERR    = 3'd5
    } state_e;

endpackage : imem_loader_pkg

// File: rtl/byte_word_packer.sv
// Little-endian byte-to-word assembler for the loader data phase.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   clear         synchronous flush of byte index and partial word
//   accept        a data byte is transferred this cycle
//   byte_in       the byte being transferred
//   word_c        completed word (valid while word_ready_c is high)
//   word_ready_c  the accepted byte completes a word (byte index 3)
module byte_word_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              accept,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [WORD_W-1:0] word_c,
    output logic              word_ready_c
);

    localparam int unsigned LOW_W = WORD_W - BYTE_W;

    logic [1:0]       idx_q;
    logic [LOW_W-1:0] low_q;

    // The fourth byte is taken straight from the input so the word is
    // available on the same edge that accepts it.
    assign word_c       = {byte_in, low_q};
    assign word_ready_c = accept && (idx_q == 2'd3);

    // Byte index and lower three bytes of the word under assembly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= 2'd0;
            low_q <= '0;
        end else if (clear) begin
            idx_q <= 2'd0;
            low_q <= '0;
        end else if (accept) begin
            idx_q <= idx_q + 2'd1;
            case (idx_q)
                2'd0:    low_q[7:0]   <= byte_in;
                2'd1:    low_q[15:8]  <= byte_in;
                2'd2:    low_q[23:16] <= byte_in;
                default: low_q        <= low_q;
            endcase
        end
    end

endmodule : byte_word_packer

// File: rtl/imem_loader.sv
// Boot-time loader: parses a 2-byte little-endian word count, packs the
// following bytes into 32-bit words and writes them to instruction memory
// at sequential addresses, holding the CPU in reset until the load ends.
// Build macro: IMEM_LOADER_CHECKSUM_EN appends a trailing XOR checksum byte.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid, in_data   byte stream from host; in_ready is the handshake
//   restart             pulse that starts a new load from DONE or ERR
//   wr_en/addr/data     instruction memory write port
//   cpu_hold            holds the CPU in reset while low-level load runs
//   done, err           load outcome flags
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = IMEM_ADDR_W,
    parameter int unsigned CNT_W  = IMEM_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              in_ready,
    input  logic              restart,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    localparam int unsigned DEPTH = 2**ADDR_W;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_e TAIL_STATE = ST_CKSUM;
    localparam logic   TAIL_READY = 1'b1;
`else
    localparam state_e TAIL_STATE = ST_DONE;
    localparam logic   TAIL_READY = 1'b0;
`endif

    state_e             state_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   word_cnt_q;

    logic               accept_c;
    logic               restart_ok_c;
    logic [CNT_W-1:0]   hdr_count_c;
    logic               last_word_c;
    logic [WORD_W-1:0]  word_c;
    logic               word_ready_c;

    assign accept_c     = in_valid && in_ready;
    assign restart_ok_c = restart && ((state_q == ST_DONE) || (state_q == ST_ERR));
    assign hdr_count_c  = CNT_W'({in_data, count_q[7:0]});
    assign last_word_c  = (word_cnt_q == (count_q - CNT_W'(1)));

    byte_word_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .clear        (restart_ok_c),
        .accept       (accept_c && (state_q == ST_DATA)),
        .byte_in      (in_data),
        .word_c       (word_c),
        .word_ready_c (word_ready_c)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] xsum_q;
    logic              cksum_ok_c;

    assign cksum_ok_c = (in_data == xsum_q);

    // Running XOR over header and data bytes; the checksum byte itself is excluded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xsum_q <= '0;
        end else if (restart_ok_c) begin
            xsum_q <= '0;
        end else if (accept_c && (state_q != ST_CKSUM)) begin
            xsum_q <= xsum_q ^ in_data;
        end
    end
`endif

    // Loader FSM with registered handshake, write port and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_HDR_LO;
            in_ready   <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            count_q    <= '0;
            word_cnt_q <= '0;
        end else begin
            wr_en <= 1'b0;

            // Address advances on the edge after each write strobe.
            if (wr_en) begin
                word_cnt_q <= word_cnt_q + CNT_W'(1);
            end

            case (state_q)
                ST_HDR_LO: begin
                    in_ready <= 1'b1;
                    if (accept_c) begin
                        count_q[7:0] <= in_data;
                        state_q      <= ST_HDR_HI;
                    end
                end

                ST_HDR_HI: begin
                    in_ready <= 1'b1;
                    if (accept_c) begin
                        count_q <= hdr_count_c;
                        if (hdr_count_c == '0) begin
                            state_q  <= TAIL_STATE;
                            in_ready <= TAIL_READY;
                        end else if (32'(hdr_count_c) > DEPTH) begin
                            state_q  <= ST_ERR;
                            in_ready <= 1'b0;
                        end else begin
                            state_q  <= ST_DATA;
                        end
                    end
                end

                ST_DATA: begin
                    in_ready <= 1'b1;
                    if (word_ready_c) begin
                        wr_en   <= 1'b1;
                        wr_addr <= word_cnt_q[ADDR_W-1:0];
                        wr_data <= word_c;
                        if (last_word_c) begin
                            state_q  <= TAIL_STATE;
                            in_ready <= TAIL_READY;
                        end
                    end
                end

`ifdef IMEM_LOADER_CHECKSUM_EN
                ST_CKSUM: begin
                    in_ready <= 1'b1;
                    if (accept_c) begin
                        state_q  <= cksum_ok_c ? ST_DONE : ST_ERR;
                        in_ready <= 1'b0;
                    end
                end
`endif

                ST_DONE: begin
                    in_ready <= 1'b0;
                    done     <= 1'b1;
                    cpu_hold <= 1'b0;
                    err      <= 1'b0;
                end

                ST_ERR: begin
                    in_ready <= 1'b0;
                    done     <= 1'b0;
                    cpu_hold <= 1'b1;
                    err      <= 1'b1;
                end

                default: begin
                    state_q  <= ST_HDR_LO;
                    in_ready <= 1'b0;
                end
            endcase

            // Restart overrides the terminal-state outputs on the same edge.
            if (restart_ok_c) begin
                state_q    <= ST_HDR_LO;
                in_ready   <= 1'b1;
                done       <= 1'b0;
                err        <= 1'b0;
                cpu_hold   <= 1'b1;
                wr_addr    <= '0;
                word_cnt_q <= '0;
                count_q    <= '0;
            end
        end
    end

endmodule : imem_loader
